// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control path: controller states,
// the hardwired-zero register index and default multiply/fetch timing.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun,
    StMulw,
    StDone
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned MulLatDefault      = 4;
  localparam int unsigned ImemTimeoutDefault = 64;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the instruction in ID reads.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic [4:0] ex_rt_i,
  input  logic       ex_mem_read_i,
  output logic       load_use_o
);

  assign load_use_o = ex_mem_read_i && (ex_rt_i != REG_ZERO) &&
                      ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, redirects,
// fetch wait states, multi-cycle multiply sequencing, fetch timeout and stall counting.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT      = MulLatDefault,
  parameter int unsigned IMEM_TIMEOUT = ImemTimeoutDefault,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic [4:0]       exRt,
  input  logic             exMemRead,
  input  logic             exMulStart,
  input  logic             branchTaken,
  input  logic             jump,
  input  logic             imemReady,
  output logic             pcLd,
  output logic             ifidLd,
  output logic             ifidFlush,
  output logic             idexLd,
  output logic             idexFlush,
  output logic             exmemFlush,
  output logic             fetchErr,
  output logic [CNT_W-1:0] stallCycles
);

  localparam int unsigned CntW  = $clog2(MUL_LAT);
  localparam int unsigned WaitW = $clog2(IMEM_TIMEOUT) + 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(IMEM_TIMEOUT - 1);

  ctrl_state_e      state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic load_use, mul_hold, fetch_wait;
  logic pc_ld, ifid_ld, ifid_flush, idex_ld, idex_flush, exmem_flush;

  hazard_detect u_hazard_detect (
    .id_rs_i       (idRs),
    .id_rt_i       (idRt),
    .ex_rt_i       (exRt),
    .ex_mem_read_i (exMemRead),
    .load_use_o    (load_use)
  );

  // DONE ignores exMulStart: the finished multiply is still in EX for that cycle.
  assign mul_hold = (state_q == StMulw) || ((state_q == StRun) && exMulStart);

  always_comb begin
    pc_ld       = 1'b1;
    ifid_ld     = 1'b1;
    ifid_flush  = 1'b0;
    idex_ld     = 1'b1;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    fetch_wait  = 1'b0;
    if (rst) begin
      pc_ld   = 1'b0;
      ifid_ld = 1'b0;
      idex_ld = 1'b0;
    end else if (mul_hold) begin
      pc_ld       = 1'b0;
      ifid_ld     = 1'b0;
      idex_ld     = 1'b0;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_ld      = 1'b0;
      ifid_ld    = 1'b0;
      idex_ld    = 1'b0;
      idex_flush = 1'b1;
    end else if (branchTaken || jump) begin
      ifid_ld    = 1'b0;
      ifid_flush = 1'b1;
    end else if (!imemReady) begin
      pc_ld      = 1'b0;
      ifid_ld    = 1'b0;
      ifid_flush = 1'b1;
      fetch_wait = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StRun: begin
        if (exMulStart) begin
          cnt_d   = CntW'(MUL_LAT - 2);
          state_d = (MUL_LAT > 2) ? StMulw : StDone;
        end
      end
      StMulw: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StDone;
      end
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (imemReady) begin
      wait_cnt_d = '0;
    end else if (fetch_wait && (wait_cnt_q != WaitMax)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    // wait_cnt saturates at WaitMax, so equality means the timeout was reached.
    fetch_err_d    = fetch_err_q | (fetch_wait && (wait_cnt_q == WaitMax));
    stall_cycles_d = stall_cycles_q;
    if (!pc_ld && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StRun;
      cnt_q          <= '0;
      wait_cnt_q     <= '0;
      fetch_err_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      fetch_err_q    <= fetch_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pcLd        = pc_ld;
  assign ifidLd      = ifid_ld;
  assign ifidFlush   = ifid_flush;
  assign idexLd      = idex_ld;
  assign idexFlush   = idex_flush;
  assign exmemFlush  = exmem_flush;
  assign fetchErr    = fetch_err_q;
  assign stallCycles = stall_cycles_q;

endmodule
